// File: rtl/dot_product_pkg.sv
// Shared types and constants for the dot-product accumulation stage.
package dot_product_pkg;

  localparam int DOT_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Width that holds max_chunks full-scale partials without overflow.
  function automatic int acc_width(input int dot_w, input int max_chunks);
    return dot_w + $clog2(max_chunks);
  endfunction

endpackage

// File: rtl/dot_product_chunk_accumulator.sv
// Sums num_chunks partial dot products; result valid the cycle after the last chunk, held until acc_ready.
// Stalls upstream (in_ready=0) while holding a result; DOT_ACC_ERR_EN adds a sticky dropped-chunk err flag.
module dot_product_chunk_accumulator
  import dot_product_pkg::*;
#(
  parameter int MAX_CHUNKS = 16,
  parameter int DOT_W      = dot_product_pkg::DOT_W,
  parameter int ACC_W      = acc_width(DOT_W, MAX_CHUNKS),
  localparam int CNT_W     = $clog2(MAX_CHUNKS) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] num_chunks,
  input  logic             abort,
  input  logic [DOT_W-1:0] in_dot,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready
`ifdef DOT_ACC_ERR_EN
  ,
  output logic             err
`endif
);

  acc_state_e       state, state_nxt;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] target_clamped;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic             accept;

  assign accept  = in_valid && in_ready;
  assign acc_out = acc;

  always_comb begin
    target_clamped = num_chunks;
    if (num_chunks == '0) begin
      target_clamped = CNT_W'(1);
    end else if (num_chunks > CNT_W'(MAX_CHUNKS)) begin
      target_clamped = CNT_W'(MAX_CHUNKS);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = (target_clamped == CNT_W'(1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept && (cnt + CNT_W'(1) == target)) begin
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state != HOLD);
    acc_valid = (state == HOLD);
  end

  // in_ready is low in HOLD, so acc only moves in IDLE/ACCUM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      target <= '0;
    end else if (abort) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      if (state == IDLE) begin
        target <= target_clamped;
        acc    <= ACC_W'(in_dot);
        cnt    <= CNT_W'(1);
      end else begin
        acc <= acc + ACC_W'(in_dot);
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef DOT_ACC_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (abort) begin
      err <= 1'b0;
    end else if (in_valid && !in_ready) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dot_product_chunk_accumulator.sv
// Directed bench for dot_product_chunk_accumulator; inputs driven and outputs sampled on the falling edge.
module tb_dot_product_chunk_accumulator;

  localparam int DOT_W = 19;
  localparam int ACC_W = 23;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       num_chunks;
  logic             abort;
  logic [DOT_W-1:0] in_dot;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_valid;
  logic             acc_ready;
`ifdef DOT_ACC_ERR_EN
  logic             err;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dot_product_chunk_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .num_chunks (num_chunks),
    .abort      (abort),
    .in_dot     (in_dot),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready)
`ifdef DOT_ACC_ERR_EN
    ,
    .err        (err)
`endif
  );

  // Presents one chunk for one rising edge; starts and ends on a falling edge.
  task automatic push(input logic [DOT_W-1:0] v);
    in_valid = 1'b1;
    in_dot   = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_dot = '0;
    acc_ready = 1'b1; num_chunks = 5'd4;
    @(negedge clk);
    @(negedge clk);
    total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", acc_valid); end
    total++; if (acc_out !== 23'd0) begin bad++; $display("FAIL reset_out got=%0d exp=0", acc_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", in_ready); end
`ifdef DOT_ACC_ERR_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
`endif
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    num_chunks = 5'd4; acc_ready = 1'b1;
    push(19'd100); push(19'd200); push(19'd300);
    total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=%0b exp=0", acc_valid); end
    push(19'd400);
    total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b exp=1", acc_valid); end
    total++; if (acc_out !== 23'd1000) begin bad++; $display("FAIL b2b_sum got=%0d exp=1000", acc_out); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_hold_ready got=%0b exp=0", in_ready); end
    @(negedge clk);
    total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL b2b_one_cycle got=%0b exp=0", acc_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_max_values();
    num_chunks = 5'd16; acc_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(19'd520200);
    total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL max_valid got=%0b exp=1", acc_valid); end
    total++; if (acc_out !== 23'd8323200) begin bad++; $display("FAIL max_sum got=%0d exp=8323200", acc_out); end
    @(negedge clk);
  endtask

  task automatic test_num_chunks_edges();
    acc_ready = 1'b1;
    num_chunks = 5'd0;
    push(19'd7);
    total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL n0_valid got=%0b exp=1", acc_valid); end
    total++; if (acc_out !== 23'd7) begin bad++; $display("FAIL n0_sum got=%0d exp=7", acc_out); end
    @(negedge clk);
    num_chunks = 5'd1;
    push(19'd7);
    total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL n1_valid got=%0b exp=1", acc_valid); end
    total++; if (acc_out !== 23'd7) begin bad++; $display("FAIL n1_sum got=%0d exp=7", acc_out); end
    @(negedge clk);
    num_chunks = 5'd20;
    for (int i = 0; i < 15; i++) push(19'd1);
    total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL n20_early_valid got=%0b exp=0", acc_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL n20_ready got=%0b exp=1", in_ready); end
    push(19'd1);
    total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL n20_valid got=%0b exp=1", acc_valid); end
    total++; if (acc_out !== 23'd16) begin bad++; $display("FAIL n20_sum got=%0d exp=16", acc_out); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    num_chunks = 5'd2; acc_ready = 1'b0;
    push(19'd5); push(19'd6);
    for (int i = 0; i < 5; i++) begin
      total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%0b exp=1", i, acc_valid); end
      total++; if (acc_out !== 23'd11) begin bad++; $display("FAIL bp_sum cyc=%0d got=%0d exp=11", i, acc_out); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready cyc=%0d got=%0b exp=0", i, in_ready); end
      in_valid = 1'b1; in_dot = 19'd99;
      @(negedge clk);
    end
    in_valid = 1'b0; acc_ready = 1'b1;
    @(negedge clk);
    total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL bp_drain_valid got=%0b exp=0", acc_valid); end
    total++; if (acc_out !== 23'd11) begin bad++; $display("FAIL bp_not_accepted got=%0d exp=11", acc_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_drain_ready got=%0b exp=1", in_ready); end
`ifdef DOT_ACC_ERR_EN
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bp_err got=%0b exp=1", err); end
`endif
  endtask

  task automatic test_abort();
    num_chunks = 5'd4; acc_ready = 1'b1;
    push(19'd100); push(19'd200);
    abort = 1'b1; in_valid = 1'b1; in_dot = 19'd50;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
    total++; if (acc_out !== 23'd0) begin bad++; $display("FAIL abort_clear got=%0d exp=0", acc_out); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%0b exp=1", in_ready); end
`ifdef DOT_ACC_ERR_EN
    total++; if (err !== 1'b0) begin bad++; $display("FAIL abort_err got=%0b exp=0", err); end
`endif
    num_chunks = 5'd2;
    push(19'd1); push(19'd2);
    total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL abort_new_valid got=%0b exp=1", acc_valid); end
    total++; if (acc_out !== 23'd3) begin bad++; $display("FAIL abort_new_sum got=%0d exp=3", acc_out); end
    @(negedge clk);
    acc_ready = 1'b0; num_chunks = 5'd1;
    push(19'd9);
    total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL abort_hold_pre got=%0b exp=1", acc_valid); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL abort_hold_valid got=%0b exp=0", acc_valid); end
    total++; if (acc_out !== 23'd0) begin bad++; $display("FAIL abort_hold_out got=%0d exp=0", acc_out); end
    acc_ready = 1'b1;
  endtask

  task automatic test_reset_mid_job();
    num_chunks = 5'd4; acc_ready = 1'b1;
    push(19'd10); push(19'd20);
    total++; if (acc_out !== 23'd30) begin bad++; $display("FAIL rst_mid_partial got=%0d exp=30", acc_out); end
    rst = 1'b1;
    #1;
    total++; if (acc_out !== 23'd0) begin bad++; $display("FAIL rst_mid_out got=%0d exp=0", acc_out); end
    total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%0b exp=0", acc_valid); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    num_chunks = 5'd3;
    push(19'd10); push(19'd20); push(19'd30);
    total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL rst_after_valid got=%0b exp=1", acc_valid); end
    total++; if (acc_out !== 23'd60) begin bad++; $display("FAIL rst_after_sum got=%0d exp=60", acc_out); end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_max_values();
    test_num_chunks_edges();
    test_backpressure();
    test_abort();
    test_reset_mid_job();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
